// File: rtl/audio_sample_fifo.sv
// FWFT 48-bit stereo sample buffer with a prefill FILL/PLAY machine that gates the DAC driver via o_wait.
// Optional drop/underrun counters are built when AUDIO_FIFO_STATS_EN is defined.
module audio_sample_fifo #(
  parameter int DEPTH   = 64,
  parameter int PREFILL = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          i_clk36,
  input  logic          i_rst36,
  input  logic          i_flush,
  input  logic          i_wr_valid,
  input  logic [47:0]   i_wr_data,
  output logic          o_wr_ready,
  input  logic          i_rdreq,
  output logic [47:0]   o_lraudio,
  output logic          o_wait,
  output logic [AW:0]   o_level,
  output logic          o_playing
`ifdef AUDIO_FIFO_STATS_EN
  ,
  input  logic          i_stats_clr,
  output logic [15:0]   o_overflows,
  output logic [15:0]   o_underruns
`endif
);

  localparam logic [0:0]  S_FILL    = 1'b0;
  localparam logic [0:0]  S_PLAY    = 1'b1;
  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRE_LVL   = (AW+1)'(PREFILL);

  logic [47:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [0:0]    state_q, state_d;
  logic          wait_q, playing_q;
  logic          wr_acc, rd_acc;

  assign o_wr_ready = (level_q != FULL_LVL) && !i_flush;
  assign wr_acc     = i_wr_valid && o_wr_ready;
  // Flush wins over a pop in the same cycle.
  assign rd_acc     = i_rdreq && (level_q != '0) && !i_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      level_d = level_q + (AW+1)'(1);
      else if (rd_acc && !wr_acc) level_d = level_q - (AW+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_FILL;
    end else if (state_q == S_FILL) begin
      if (level_d >= PRE_LVL) state_d = S_PLAY;
    end else if (rd_acc && !wr_acc && (level_d == '0)) begin
      state_d = S_FILL;
    end
  end

  always_ff @(posedge i_clk36 or posedge i_rst36) begin
    if (i_rst36) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= S_FILL;
      wait_q    <= 1'b1;
      playing_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      wait_q    <= (state_d == S_FILL);
      playing_q <= (state_d == S_PLAY);
    end
  end

  // Storage is deliberately not reset; an empty level masks stale contents.
  always_ff @(posedge i_clk36) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_lraudio = (level_q != '0) ? mem_q[rd_ptr_q] : 48'h0;
  assign o_wait    = wait_q;
  assign o_playing = playing_q;
  assign o_level   = level_q;

`ifdef AUDIO_FIFO_STATS_EN
  logic [15:0] ovf_q, und_q;
  logic        ovf_inc, und_inc;

  assign ovf_inc = i_wr_valid && !o_wr_ready && !i_flush;
  assign und_inc = ((state_q == S_PLAY) && (state_d == S_FILL) && !i_flush)
                 || (i_rdreq && (level_q == '0));

  always_ff @(posedge i_clk36 or posedge i_rst36) begin
    if (i_rst36) begin
      ovf_q <= '0;
      und_q <= '0;
    end else if (i_stats_clr) begin
      ovf_q <= '0;
      und_q <= '0;
    end else begin
      if (ovf_inc && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
      if (und_inc && (und_q != 16'hFFFF)) und_q <= und_q + 16'd1;
    end
  end

  assign o_overflows = ovf_q;
  assign o_underruns = und_q;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_audio_sample_fifo;
  localparam int DEPTH   = 64;
  localparam int PREFILL = 32;
  localparam int AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, wr_valid, rdreq;
  logic [47:0]   wr_data;
  logic          wr_ready, o_wait, playing;
  logic [47:0]   lraudio;
  logic [AW:0]   level;
`ifdef AUDIO_FIFO_STATS_EN
  logic          stats_clr;
  logic [15:0]   overflows, underruns;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  audio_sample_fifo #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .i_clk36   (clk),
    .i_rst36   (rst),
    .i_flush   (flush),
    .i_wr_valid(wr_valid),
    .i_wr_data (wr_data),
    .o_wr_ready(wr_ready),
    .i_rdreq   (rdreq),
    .o_lraudio (lraudio),
    .o_wait    (o_wait),
    .o_level   (level),
    .o_playing (playing)
`ifdef AUDIO_FIFO_STATS_EN
    ,
    .i_stats_clr(stats_clr),
    .o_overflows(overflows),
    .o_underruns(underruns)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] smp(input int i);
    return {8'hA5, i[15:0], 8'h3C, ~i[15:0]};
  endfunction

  // Reference model: a plain queue of accepted samples plus a playing flag.
  logic [47:0] q[$];
  bit          m_play;
  int          m_ovf, m_und;

  always @(posedge clk or posedge rst) begin : model
    int sz;
    bit do_pop, do_push;
    if (rst) begin
      q.delete();
      m_play = 0;
      m_ovf  = 0;
      m_und  = 0;
    end else begin
      sz = q.size();
`ifdef AUDIO_FIFO_STATS_EN
      if (stats_clr) begin
        m_ovf = 0;
        m_und = 0;
      end else begin
        if (wr_valid && !flush && sz == DEPTH && m_ovf < 65535) m_ovf++;
        if (rdreq && sz == 0 && m_und < 65535) m_und++;
        if (!flush && m_play && rdreq && sz == 1 && !wr_valid && m_und < 65535) m_und++;
      end
`endif
      if (flush) begin
        q.delete();
        m_play = 0;
      end else begin
        do_pop  = rdreq && sz > 0;
        do_push = wr_valid && sz < DEPTH;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(wr_data);
        if (!m_play && q.size() >= PREFILL) m_play = 1;
        else if (m_play && do_pop && !do_push && q.size() == 0) m_play = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    chk("level",    64'(level),    64'(q.size()));
    chk("wait",     64'(o_wait),   64'(!m_play));
    chk("playing",  64'(playing),  64'(m_play));
    chk("lraudio",  64'(lraudio),  (q.size() != 0) ? 64'(q[0]) : 64'h0);
    chk("wr_ready", 64'(wr_ready), 64'((q.size() != DEPTH) && !flush));
`ifdef AUDIO_FIFO_STATS_EN
    chk("overflows", 64'(overflows), 64'(m_ovf));
    chk("underruns", 64'(underruns), 64'(m_und));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rdreq    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic write(input logic [47:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"},    64'(level),    64'd0);
    chk({tag, "_wait"},     64'(o_wait),   64'd1);
    chk({tag, "_playing"},  64'(playing),  64'd0);
    chk({tag, "_lraudio"},  64'(lraudio),  64'h0);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    wr_data = '0;
    idle();
`ifdef AUDIO_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    #23;
    check_reset_outputs("rst0");
    cyc();
    rst = 1'b0;

    // Prefill: 31 samples keeps the driver waiting, the 32nd releases it.
    for (int i = 0; i < 31; i++) write(smp(i));
    chk("pre31_level", 64'(level),  64'd31);
    chk("pre31_wait",  64'(o_wait), 64'd1);
    write(smp(31));
    chk("pre32_wait",    64'(o_wait),  64'd0);
    chk("pre32_playing", 64'(playing), 64'd1);
    chk("pre32_head",    64'(lraudio), 64'(smp(0)));

    // Steady state: one write and one pop per 768-cycle frame.
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1;
      wr_data  = smp(32 + k);
      rdreq    = 1'b1;
      cyc();
      idle();
      chk("steady_level", 64'(level),   64'd32);
      chk("steady_head",  64'(lraudio), 64'(smp(k + 1)));
      repeat (767) cyc();
    end

    // Fill to full, then offer a sample that must be dropped.
    for (int i = 36; i < 68; i++) write(smp(i));
    chk("full_level", 64'(level), 64'd64);
    wr_valid = 1'b1;
    wr_data  = 48'hABCDEF_123456;
    #1;
    chk("full_wr_ready", 64'(wr_ready), 64'd0);
    cyc();
    idle();
    chk("full_level_after_drop", 64'(level), 64'd64);

    // Drain everything, checking order and that the dropped sample never appears.
    for (int j = 0; j < 64; j++) begin
      chk("drain_order", 64'(lraudio), 64'(smp(4 + j)));
      chk("drain_no_drop", 64'(lraudio == 48'hABCDEF_123456), 64'd0);
      rdreq = 1'b1;
      cyc();
      idle();
    end
    chk("drained_wait",    64'(o_wait),  64'd1);
    chk("drained_playing", 64'(playing), 64'd0);
    chk("drained_lraudio", 64'(lraudio), 64'h0);
    chk("drained_level",   64'(level),   64'd0);
    rdreq = 1'b1;
    cyc();
    idle();
    chk("empty_rdreq_level", 64'(level), 64'd0);
`ifdef AUDIO_FIFO_STATS_EN
    chk("stats_overflows", 64'(overflows), 64'd1);
    chk("stats_underruns", 64'(underruns), 64'd2);
`endif

    // Flush with a same-cycle write and pop at level 10.
    for (int i = 0; i < 10; i++) write(smp(100 + i));
    chk("preflush_level", 64'(level), 64'd10);
    flush    = 1'b1;
    wr_valid = 1'b1;
    rdreq    = 1'b1;
    wr_data  = 48'hFFFF00_FFFF00;
    cyc();
    idle();
    chk("flush_level",   64'(level),   64'd0);
    chk("flush_wait",    64'(o_wait),  64'd1);
    chk("flush_lraudio", 64'(lraudio), 64'h0);
    write(smp(200));
    chk("postflush_head",  64'(lraudio), 64'(smp(200)));
    chk("postflush_level", 64'(level),   64'd1);

`ifdef AUDIO_FIFO_STATS_EN
    chk("flush_overflows", 64'(overflows), 64'd1);
    stats_clr = 1'b1;
    cyc();
    stats_clr = 1'b0;
    chk("clr_overflows", 64'(overflows), 64'd0);
    chk("clr_underruns", 64'(underruns), 64'd0);
`endif

    // Asynchronous reset between edges, mid-stream.
    for (int i = 0; i < 19; i++) write(smp(300 + i));
    chk("prerst_level", 64'(level), 64'd20);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 31; i++) write(smp(400 + i));
    chk("re31_wait",  64'(o_wait), 64'd1);
    chk("re31_level", 64'(level),  64'd31);
    write(smp(431));
    chk("re32_playing", 64'(playing), 64'd1);
    chk("re32_head",    64'(lraudio), 64'(smp(400)));
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_sample_fifo.md
Name: audio_sample_fifo

Overview:
- Sample buffer that sits directly upstream of the PCM1780 DAC driver, in the 36.864MHz domain.
- Accepts 48-bit stereo samples ({left[47:24], right[23:0]}) from the packet-parsing stage and presents them first-word-fall-through to the driver.
- The driver pops one sample per 48kHz frame using a wait/read-request pair.
- Prefill state machine: o_wait is held high until a safety margin of samples is buffered, and is re-armed after an underrun.

Parameters:
- DEPTH, 64, number of 48-bit entries; power of two, >= 4.
- PREFILL, 32, level required to leave FILL; 1 <= PREFILL <= DEPTH.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- i_clk36  in  1  36.864MHz clock.
- i_rst36  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear: empties buffer, returns to FILL.
- i_wr_valid  in  1  write strobe from upstream.
- i_wr_data  in  48  sample {left, right}.
- o_wr_ready  out  1  high when a write will be accepted this cycle.
- i_rdreq  in  1  1-cycle pop pulse from DAC driver.
- o_lraudio  out  48  head-of-buffer sample (FWFT).
- o_wait  out  1  high = driver must not request.
- o_level  out  AW+1  current occupancy, 0..DEPTH.
- o_playing  out  1  high in PLAY state.

Behaviour:
- Reset (async assert, released synchronously to i_clk36):
  - pointers = 0, level = 0, state = FILL.
  - o_wait = 1, o_playing = 0, o_lraudio = 0, o_wr_ready = 1.
- Storage: register array DEPTH x 48, write pointer and read pointer of AW bits, wrapping modulo DEPTH. o_level is a separate registered counter.
- Write:
  - o_wr_ready = (level != DEPTH) && !i_flush, combinational from registered level.
  - A write is accepted when i_wr_valid && o_wr_ready: data is stored at the write pointer, and the pointer and level advance at the next edge.
  - i_wr_valid && !o_wr_ready: sample is dropped, with no state change. The upstream stage does not stall.
- Read:
  - o_lraudio = mem[rd_ptr] when level != 0, else 48'h0.
  - Head is stable until popped. The driver captures it up to one cycle before its i_rdreq pulse.
  - Pop when i_rdreq && level != 0: rd_ptr and level update at the next edge.
  - i_rdreq with level == 0 is ignored; pointers and level are unchanged.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - When full, o_wr_ready is already low, so the write is rejected even if a pop occurs in the same cycle.
  - When empty, the write is accepted and the pop is ignored.
- State machine (registered):
  - FILL: o_wait = 1. Move to PLAY at the edge where the next level >= PREFILL.
  - PLAY: o_wait = 0. Move to FILL at the edge where a pop leaves the next level == 0 with no accepted write in the same cycle. o_wait rises in that same cycle.
  - o_wait and o_playing are registered outputs, decoded from the state register.
- i_flush:
  - Takes priority over reads and writes in its cycle.
  - Next cycle: pointers = 0, level = 0, state = FILL. Buffer contents are not cleared; o_lraudio reads 0 because level = 0.
- Arithmetic:
  - level is AW+1 bits and never exceeds DEPTH or goes below 0.
  - Pointer wrap from DEPTH-1 to 0 has no special case.

Optional Feature:
- Macro: AUDIO_FIFO_STATS_EN.
- With the macro defined, add:
  - i_stats_clr (in, 1): synchronous clear of both counters.
  - o_overflows (out, 16): counts cycles with i_wr_valid && !o_wr_ready, excluding flush cycles.
  - o_underruns (out, 16): counts transitions PLAY->FILL caused by draining, plus i_rdreq pulses seen while level == 0.
  - Both counters saturate at 16'hFFFF. They reset to 0 on i_rst36 and on i_stats_clr; i_stats_clr wins over a same-cycle increment.
- Without the macro: these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset then write 31 samples (DEPTH=64, PREFILL=32) -> o_wait stays 1, o_level = 31. Write 32nd -> o_wait = 0 and o_playing = 1 the next cycle. o_lraudio = first sample written.
- In PLAY, pulse i_rdreq once per 768 cycles while writing at the same rate -> o_level constant, samples emerge in order, no gaps.
- Fill to 64 then assert i_wr_valid with data 48'hABCDEF_123456 -> o_wr_ready = 0, sample is absent from the read stream, o_level stays 64 (stats: o_overflows = 1).
- Drain all 64 via i_rdreq with no writes -> on the last pop o_wait = 1, state = FILL, o_lraudio = 0. A further i_rdreq leaves o_level = 0 (stats: o_underruns = 2).
- With o_level = 10, assert i_flush together with i_wr_valid and i_rdreq -> next cycle o_level = 0 and o_wait = 1. Next write lands at address 0 and appears on o_lraudio.
- Assert i_rst36 mid-stream, asynchronously between edges -> outputs go to their reset values immediately. After release, the prefill sequence repeats from level 0.
